traffic_light_monitor: RTL and testbench

- Passive checker on the light-control side of the intersection controller.
- Samples sensor inputs S1..S3 and light outputs L1..L3 (NB SW 4th Ave, EB SW Harrison, WB SW Harrison) every clock.
- Flags five fault classes, all sticky: conflicting right-of-way, illegal light sequence, short yellow, sensor starvation and illegal light code.
- Instanced beside the controller in simulation and in hardware as a safety monitor. It drives nothing back into the controller.

---
 rtl/traffic_light_monitor.sv | 135 +++++++++++++
 tb/tb_traffic_light_monitor.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_monitor.sv
// Passive safety monitor for the three-light intersection controller.
// Samples sensors and light codes every clock and latches sticky fault flags.
module traffic_light_monitor #(
  parameter int YELLOW_MIN = 3,
  parameter int MAX_WAIT   = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_clear,
  input  logic       i_s1,
  input  logic       i_s2,
  input  logic       i_s3,
  input  logic [1:0] i_l1,
  input  logic [1:0] i_l2,
  input  logic [1:0] i_l3,
  output logic       o_fault,
  output logic [4:0] o_fault_flags,
  output logic [1:0] o_fault_light
);

  localparam int YW = $clog2(YELLOW_MIN + 1);
  localparam int WW = $clog2(MAX_WAIT + 1);

  localparam logic [1:0] LC_ILLEGAL = 2'b00;
  localparam logic [1:0] LC_GREEN   = 2'b01;
  localparam logic [1:0] LC_YELLOW  = 2'b10;
  localparam logic [1:0] LC_RED     = 2'b11;

  localparam logic [YW-1:0] YMIN    = YW'(YELLOW_MIN);
  localparam logic [WW-1:0] WMAX    = WW'(MAX_WAIT);
  localparam logic [WW-1:0] WMAX_M1 = WW'(MAX_WAIT - 1);

  logic [2:0][1:0] w_light;
  logic [2:0]      w_sens;
  logic [2:0]      w_trans;
  logic [2:0]      w_short;
  logic [2:0]      w_starve;
  logic [2:0]      w_code;
  logic [2:0]      w_lfault;
  logic            w_conflict;
  logic [4:0]      w_new_flags;
  logic [4:0]      w_flags_next;
  logic [1:0]      w_first_light;
  logic [1:0]      w_light_base;
  logic [1:0]      w_light_next;

  logic            r_primed;
  logic [4:0]      r_flags;
  logic [1:0]      r_light;

  assign w_light = {i_l3, i_l2, i_l1};
  assign w_sens  = {i_s3, i_s2, i_s1};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_light
      logic [1:0]    r_prev;
      logic [YW-1:0] r_ycnt;
      logic [WW-1:0] r_wcnt;
      logic          w_cur_g;
      logic          w_cur_y;
      logic          w_cur_r;
      logic          w_wait_cond;

      assign w_cur_g     = (w_light[gi] == LC_GREEN);
      assign w_cur_y     = (w_light[gi] == LC_YELLOW);
      assign w_cur_r     = (w_light[gi] == LC_RED);
      assign w_wait_cond = w_sens[gi] && !w_cur_g;

      assign w_code[gi]  = (w_light[gi] == LC_ILLEGAL);
      // Transitions touching code 00 are reported only as illegal code.
      assign w_trans[gi] = r_primed && !w_code[gi] && (r_prev != LC_ILLEGAL) &&
                           (((r_prev == LC_GREEN)  && w_cur_r) ||
                            ((r_prev == LC_RED)    && w_cur_y) ||
                            ((r_prev == LC_YELLOW) && w_cur_g));
      assign w_short[gi]  = r_primed && (r_prev == LC_YELLOW) && w_cur_r && (r_ycnt < YMIN);
      // Fires on the edge the counter reaches MAX_WAIT and every saturated edge after.
      assign w_starve[gi] = w_wait_cond && (r_wcnt >= WMAX_M1);
      assign w_lfault[gi] = w_trans[gi] | w_short[gi] | w_starve[gi] | w_code[gi];

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_prev <= LC_RED;
          r_ycnt <= '0;
          r_wcnt <= '0;
        end else begin
          r_prev <= w_light[gi];
          if (w_cur_y) begin
            if (r_ycnt != YMIN) r_ycnt <= r_ycnt + 1'b1;
          end else begin
            r_ycnt <= '0;
          end
          if (w_wait_cond) begin
            if (r_wcnt != WMAX) r_wcnt <= r_wcnt + 1'b1;
          end else begin
            r_wcnt <= '0;
          end
        end
      end
    end
  endgenerate

  assign w_conflict  = (i_l1 != LC_RED) && ((i_l2 != LC_RED) || (i_l3 != LC_RED));
  assign w_new_flags = {|w_code, |w_starve, |w_short, |w_trans, w_conflict};

  always_comb begin
    w_first_light = 2'd0;
    if (w_lfault[0])      w_first_light = 2'd1;
    else if (w_lfault[1]) w_first_light = 2'd2;
    else if (w_lfault[2]) w_first_light = 2'd3;
  end

  // Clear is applied first so a fault seen in the same cycle still lands.
  always_comb begin
    w_flags_next = (i_clear ? 5'd0 : r_flags) | w_new_flags;
    w_light_base = i_clear ? 2'd0 : r_light;
    w_light_next = (w_light_base == 2'd0) ? w_first_light : w_light_base;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_primed <= 1'b0;
      r_flags  <= '0;
      r_light  <= '0;
    end else begin
      r_primed <= 1'b1;
      r_flags  <= w_flags_next;
      r_light  <= w_light_next;
    end
  end

  assign o_fault       = |r_flags;
  assign o_fault_flags = r_flags;
  assign o_fault_light = r_light;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scoreboard bench for traffic_light_monitor: each step pushes its expected
// {fault, flags, light} when driven and pops it once the registered outputs settle.
module tb_traffic_light_monitor;

  localparam logic [1:0] G = 2'b01;
  localparam logic [1:0] Y = 2'b10;
  localparam logic [1:0] R = 2'b11;
  localparam logic [1:0] X = 2'b00;

  typedef struct packed {
    logic [2:0] s;
    logic [1:0] l1;
    logic [1:0] l2;
    logic [1:0] l3;
    logic       clr;
    logic [7:0] exp;
  } step_t;

  logic       clk = 1'b0;
  logic       i_rst_n;
  logic       i_clear;
  logic       i_s1, i_s2, i_s3;
  logic [1:0] i_l1, i_l2, i_l3;
  logic       o_fault;
  logic [4:0] o_fault_flags;
  logic [1:0] o_fault_light;

  logic [7:0] sb_q[$];
  int         n_cmp  = 0;
  int         n_fail = 0;

  traffic_light_monitor #(.YELLOW_MIN(3), .MAX_WAIT(16)) dut (
    .i_clk         (clk),
    .i_rst_n       (i_rst_n),
    .i_clear       (i_clear),
    .i_s1          (i_s1),
    .i_s2          (i_s2),
    .i_s3          (i_s3),
    .i_l1          (i_l1),
    .i_l2          (i_l2),
    .i_l3          (i_l3),
    .o_fault       (o_fault),
    .o_fault_flags (o_fault_flags),
    .o_fault_light (o_fault_light)
  );

  always #5 clk = ~clk;

  function automatic step_t mk(input logic [2:0] s, input logic [1:0] a, input logic [1:0] b,
                               input logic [1:0] c, input logic clr, input logic [4:0] fl,
                               input logic [1:0] lt);
    mk = {s, a, b, c, clr, (|fl), fl, lt};
  endfunction

  task automatic set_inputs(input step_t st);
    i_s1 = st.s[0]; i_s2 = st.s[1]; i_s3 = st.s[2];
    i_l1 = st.l1;   i_l2 = st.l2;   i_l3 = st.l3;
    i_clear = st.clr;
  endtask

  // Drive one step at the falling edge, queue its expectation, let one rising edge pass.
  task automatic drive(input step_t st);
    @(negedge clk);
    set_inputs(st);
    sb_q.push_back(st.exp);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] exp_v, obs;
    i_rst_n = 1'b0;
    set_inputs(mk(3'b111, G, G, X, 1'b0, 5'd0, 2'd0));
    #3;
    sb_q.push_back(8'd0);
    exp_v = sb_q.pop_front(); obs = {o_fault, o_fault_flags, o_fault_light};
    n_cmp++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL reset_async: got %b expected %b", obs, exp_v); end
    $display("reset_async obs=%b exp=%b", obs, exp_v);
    repeat (2) @(posedge clk);
    #1;
    sb_q.push_back(8'd0);
    exp_v = sb_q.pop_front(); obs = {o_fault, o_fault_flags, o_fault_light};
    n_cmp++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL reset_held: got %b expected %b", obs, exp_v); end
    $display("reset_held obs=%b exp=%b", obs, exp_v);
    @(negedge clk);
    set_inputs(mk(3'b000, R, R, R, 1'b0, 5'd0, 2'd0));
    i_rst_n = 1'b1;
  endtask

  task automatic test_legal();
    step_t q[$];
    logic [7:0] exp_v, obs;
    q.push_back(mk(3'b000, G, R, R, 1'b0, 5'd0, 2'd0));
    repeat (3) q.push_back(mk(3'b000, Y, R, R, 1'b0, 5'd0, 2'd0));
    q.push_back(mk(3'b001, R, R, R, 1'b0, 5'd0, 2'd0));
    q.push_back(mk(3'b111, R, G, G, 1'b0, 5'd0, 2'd0));
    repeat (3) q.push_back(mk(3'b001, R, Y, Y, 1'b0, 5'd0, 2'd0));
    q.push_back(mk(3'b001, R, R, R, 1'b0, 5'd0, 2'd0));
    q.push_back(mk(3'b000, R, R, R, 1'b0, 5'd0, 2'd0));
    for (int k = 0; k < q.size(); k++) begin
      drive(q[k]);
      exp_v = sb_q.pop_front(); obs = {o_fault, o_fault_flags, o_fault_light};
      n_cmp++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL legal step %0d: got %b expected %b", k, obs, exp_v); end
      $display("legal step %0d obs=%b exp=%b", k, obs, exp_v);
    end
  endtask

  task automatic test_conflict();
    step_t q[$];
    logic [7:0] exp_v, obs;
    q.push_back(mk(3'b000, G, G, R, 1'b0, 5'b00001, 2'd0));
    q.push_back(mk(3'b000, Y, Y, R, 1'b1, 5'b00001, 2'd0));
    repeat (2) q.push_back(mk(3'b000, Y, Y, R, 1'b0, 5'b00001, 2'd0));
    q.push_back(mk(3'b000, R, R, R, 1'b1, 5'd0, 2'd0));
    for (int k = 0; k < q.size(); k++) begin
      drive(q[k]);
      exp_v = sb_q.pop_front(); obs = {o_fault, o_fault_flags, o_fault_light};
      n_cmp++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL conflict step %0d: got %b expected %b", k, obs, exp_v); end
      $display("conflict step %0d obs=%b exp=%b", k, obs, exp_v);
    end
  endtask

  task automatic test_short_yellow();
    step_t q[$];
    logic [7:0] exp_v, obs;
    q.push_back(mk(3'b000, R, G, R, 1'b0, 5'd0, 2'd0));
    repeat (2) q.push_back(mk(3'b000, R, Y, R, 1'b0, 5'd0, 2'd0));
    q.push_back(mk(3'b000, R, R, R, 1'b0, 5'b00100, 2'd2));
    q.push_back(mk(3'b000, R, R, R, 1'b1, 5'd0, 2'd0));
    q.push_back(mk(3'b000, R, G, R, 1'b0, 5'd0, 2'd0));
    repeat (3) q.push_back(mk(3'b000, R, Y, R, 1'b0, 5'd0, 2'd0));
    q.push_back(mk(3'b000, R, R, R, 1'b0, 5'd0, 2'd0));
    for (int k = 0; k < q.size(); k++) begin
      drive(q[k]);
      exp_v = sb_q.pop_front(); obs = {o_fault, o_fault_flags, o_fault_light};
      n_cmp++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL short_yellow step %0d: got %b expected %b", k, obs, exp_v); end
      $display("short_yellow step %0d obs=%b exp=%b", k, obs, exp_v);
    end
  endtask

  task automatic test_starvation();
    step_t q[$];
    logic [7:0] exp_v, obs;
    repeat (15) q.push_back(mk(3'b100, R, R, R, 1'b0, 5'd0, 2'd0));
    q.push_back(mk(3'b100, R, R, R, 1'b0, 5'b01000, 2'd3));
    q.push_back(mk(3'b100, R, R, R, 1'b1, 5'b01000, 2'd3));
    q.push_back(mk(3'b000, R, R, R, 1'b1, 5'd0, 2'd0));
    repeat (2) begin
      repeat (15) q.push_back(mk(3'b100, R, R, R, 1'b0, 5'd0, 2'd0));
      q.push_back(mk(3'b000, R, R, R, 1'b0, 5'd0, 2'd0));
    end
    for (int k = 0; k < q.size(); k++) begin
      drive(q[k]);
      exp_v = sb_q.pop_front(); obs = {o_fault, o_fault_flags, o_fault_light};
      n_cmp++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL starvation step %0d: got %b expected %b", k, obs, exp_v); end
      $display("starvation step %0d obs=%b exp=%b", k, obs, exp_v);
    end
  endtask

  task automatic test_simultaneous();
    step_t q[$];
    logic [7:0] exp_v, obs;
    q.push_back(mk(3'b000, G, R, R, 1'b0, 5'd0, 2'd0));
    q.push_back(mk(3'b000, R, R, X, 1'b0, 5'b10010, 2'd1));
    q.push_back(mk(3'b000, R, R, R, 1'b1, 5'd0, 2'd0));
    q.push_back(mk(3'b000, R, R, G, 1'b0, 5'd0, 2'd0));
    q.push_back(mk(3'b000, R, R, Y, 1'b0, 5'd0, 2'd0));
    q.push_back(mk(3'b000, R, R, G, 1'b0, 5'b00010, 2'd3));
    q.push_back(mk(3'b000, R, R, Y, 1'b1, 5'd0, 2'd0));
    repeat (2) q.push_back(mk(3'b000, R, R, Y, 1'b0, 5'd0, 2'd0));
    q.push_back(mk(3'b000, R, R, R, 1'b0, 5'd0, 2'd0));
    for (int k = 0; k < q.size(); k++) begin
      drive(q[k]);
      exp_v = sb_q.pop_front(); obs = {o_fault, o_fault_flags, o_fault_light};
      n_cmp++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL simultaneous step %0d: got %b expected %b", k, obs, exp_v); end
      $display("simultaneous step %0d obs=%b exp=%b", k, obs, exp_v);
    end
  endtask

  task automatic test_reset_mid();
    step_t q[$];
    logic [7:0] exp_v, obs;
    drive(mk(3'b000, G, G, R, 1'b0, 5'b00001, 2'd0));
    exp_v = sb_q.pop_front(); obs = {o_fault, o_fault_flags, o_fault_light};
    n_cmp++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL reset_mid_pre: got %b expected %b", obs, exp_v); end
    $display("reset_mid_pre obs=%b exp=%b", obs, exp_v);
    @(negedge clk);
    #2 i_rst_n = 1'b0;
    set_inputs(mk(3'b000, Y, R, R, 1'b0, 5'd0, 2'd0));
    #1;
    sb_q.push_back(8'd0);
    exp_v = sb_q.pop_front(); obs = {o_fault, o_fault_flags, o_fault_light};
    n_cmp++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL reset_mid_async: got %b expected %b", obs, exp_v); end
    $display("reset_mid_async obs=%b exp=%b", obs, exp_v);
    @(negedge clk);
    i_rst_n = 1'b1;
    @(posedge clk);
    #1;
    sb_q.push_back(8'd0);
    exp_v = sb_q.pop_front(); obs = {o_fault, o_fault_flags, o_fault_light};
    n_cmp++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL reset_mid_first_yellow: got %b expected %b", obs, exp_v); end
    $display("reset_mid_first_yellow obs=%b exp=%b", obs, exp_v);
    repeat (2) q.push_back(mk(3'b000, Y, R, R, 1'b0, 5'd0, 2'd0));
    q.push_back(mk(3'b000, R, R, R, 1'b0, 5'd0, 2'd0));
    for (int k = 0; k < q.size(); k++) begin
      drive(q[k]);
      exp_v = sb_q.pop_front(); obs = {o_fault, o_fault_flags, o_fault_light};
      n_cmp++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL reset_mid step %0d: got %b expected %b", k, obs, exp_v); end
      $display("reset_mid step %0d obs=%b exp=%b", k, obs, exp_v);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_legal();
    test_conflict();
    test_short_yellow();
    test_starvation();
    test_simultaneous();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
